// File: rtl/alu_pkg.sv
// Shared ALU types, default widths and opcodes.
// Used by the ALU, its sequencer and benches.
package alu_pkg;

  localparam int ALU_DATA_W = 6;
  localparam int ALU_OP_W   = 3;
  localparam int ALU_RES_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_EXEC,
    ST_DONE
  } seq_state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_CAT = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_shifter.sv
// Parallel-load MSB-first opcode shifter with bit counter.
// Ports: i_load/i_data load, i_shift advances, o_msb/o_last.
module alu_op_shifter
  import alu_pkg::*;
#(
  parameter int OP_W  = ALU_OP_W,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_shift,
  input  logic [OP_W-1:0] i_data,
  output logic            o_msb,
  output logic            o_last
);

  logic [OP_W-1:0]  r_sreg;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_sreg <= r_sreg << 1;
      // wrap so the next load starts from a clean count
      r_cnt  <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_msb  = r_sreg[OP_W-1];
  assign o_last = (r_cnt == CNT_W'(OP_W - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one ALU op: clear, serial opcode, wait, capture.
// Ports: start/opcode/a_in/b_in request, ready/done/result, alu_* to ALU.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W   = ALU_DATA_W,
  parameter int OP_W     = ALU_OP_W,
  parameter int RES_W    = ALU_RES_W,
  parameter int EXEC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              ready,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_instr_bit,
  output logic              alu_load_en,
  output logic              alu_instr_clr,
  input  logic [RES_W-1:0]  alu_result
);

  localparam int CNT_W =
    $clog2(max2(OP_W, EXEC_LAT) + 1);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [CNT_W-1:0]  r_xcnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [RES_W-1:0]  r_result;

  logic w_accept;
  logic w_xlast;
  logic w_shift;
  logic w_msb;
  logic w_slast;

  assign w_accept = start & ready;
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_xlast  = (r_xcnt == CNT_W'(EXEC_LAT - 1));

  alu_op_shifter #(
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (opcode),
    .o_msb   (w_msb),
    .o_last  (w_slast)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_SHIFT;
      ST_SHIFT: if (w_slast) w_next = ST_EXEC;
      ST_EXEC:  if (w_xlast) w_next = ST_DONE;
      ST_DONE:  w_next = start ? ST_CLEAR : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready         = 1'b0;
    done          = 1'b0;
    alu_instr_clr = 1'b0;
    alu_load_en   = 1'b0;
    alu_instr_bit = 1'b0;
    unique case (r_state)
      ST_IDLE:  ready = 1'b1;
      ST_CLEAR: alu_instr_clr = 1'b1;
      ST_SHIFT: begin
        alu_load_en   = 1'b1;
        alu_instr_bit = w_msb;
      end
      ST_EXEC:  ;
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xcnt   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (r_state == ST_EXEC)
        r_xcnt <= w_xlast ? '0 : r_xcnt + CNT_W'(1);
      else
        r_xcnt <= '0;
      if (w_accept) begin
        r_a <= a_in;
        r_b <= b_in;
      end
      // sample only in the final wait cycle
      if (r_state == ST_EXEC && w_xlast)
        r_result <= alu_result;
    end
  end

  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign result = r_result;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl.
// Two instances: default latency and EXEC_LAT=3.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic clk;
  logic reset_n;
  logic start;
  logic [2:0] opcode;
  logic [5:0] a_in;
  logic [5:0] b_in;

  logic ready0, done0, ibit0, load0, clr0;
  logic [11:0] result0, alu_res0;
  logic [5:0] alu_a0, alu_b0;

  logic ready3, done3, ibit3, load3, clr3;
  logic [11:0] result3, alu_res3;
  logic [5:0] alu_a3, alu_b3;

  int total = 0;
  int bad = 0;

  alu_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .ready(ready0), .done(done0), .result(result0),
    .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_instr_bit(ibit0), .alu_load_en(load0),
    .alu_instr_clr(clr0), .alu_result(alu_res0)
  );

  alu_seq_ctrl #(.EXEC_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .ready(ready3), .done(done3), .result(result3),
    .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_instr_bit(ibit3), .alu_load_en(load3),
    .alu_instr_clr(clr3), .alu_result(alu_res3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] alu_f(
    input logic [2:0] op,
    input logic [5:0] a,
    input logic [5:0] b
  );
    case (op)
      3'd0: return 12'(a) + 12'(b);
      3'd1: return 12'(a) - 12'(b);
      3'd2: return 12'(a) * 12'(b);
      3'd3: return {6'd0, a & b};
      3'd4: return {6'd0, a | b};
      3'd5: return {a, b};
      3'd6: return {6'd0, a ^ b};
      default: return ~{a, b};
    endcase
  endfunction

  // model ALUs: serial instruction register + operation
  logic [2:0] ir0, ir3;
  int lat3;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir0 <= 3'd0;
    else if (clr0) ir0 <= 3'd0;
    else if (load0) ir0 <= {ir0[1:0], ibit0};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir3 <= 3'd0;
      lat3 <= 100;
    end else begin
      if (clr3) ir3 <= 3'd0;
      else if (load3) ir3 <= {ir3[1:0], ibit3};
      if (load3) lat3 <= 0;
      else if (lat3 < 100) lat3 <= lat3 + 1;
    end
  end

  assign alu_res0 = alu_f(ir0, alu_a0, alu_b0);
  // slow ALU: correct value only from the third wait cycle
  assign alu_res3 = (lat3 >= 2) ?
    alu_f(ir3, alu_a3, alu_b3) :
    alu_f(ir3, alu_a3, alu_b3) ^ 12'hA5A;

  typedef struct {
    int first;
    int ndone;
    logic [11:0] res;
    int nclr;
    int clr_at;
    int nload;
    int load_at;
    logic [2:0] bits;
    bit ab_ok;
  } obs_t;

  task automatic accept(
    input logic [2:0] op,
    input logic [5:0] a,
    input logic [5:0] b
  );
    @(negedge clk);
    opcode = op;
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // observes dut for ncyc cycles after an accept edge
  task automatic watch(
    input int ncyc,
    input bit scramble,
    input bit poke,
    input logic [5:0] ea,
    input logic [5:0] eb,
    output obs_t o
  );
    int n;
    o.first = -1; o.ndone = 0; o.res = 'x;
    o.nclr = 0; o.clr_at = -1;
    o.nload = 0; o.load_at = -1;
    o.bits = 3'bxxx; o.ab_ok = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      n = i - 1;
      if (clr0) begin
        if (o.clr_at < 0) o.clr_at = n;
        o.nclr++;
      end
      if (load0) begin
        if (o.nload == 0) o.load_at = n;
        if (o.nload < 3) o.bits[2 - o.nload] = ibit0;
        o.nload++;
      end
      if (done0) begin
        if (o.first < 0) begin
          o.first = n;
          o.res = result0;
        end
        o.ndone++;
      end
      if (alu_a0 !== ea || alu_b0 !== eb) o.ab_ok = 1'b0;
      if (scramble) begin
        opcode = 3'($urandom);
        a_in = 6'($urandom);
        b_in = 6'($urandom);
      end
      if (poke) begin
        start = (n == 2);
        opcode = 3'b010;
        a_in = ~ea;
        b_in = ~eb;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    bit seen;
    bit rdy;
    accept(OP_ADD, 6'd9, 6'd4);
    watch(8, 0, 0, 6'd9, 6'd4, o);
    accept(OP_CAT, 6'd7, 6'd5);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({ready0, done0, ibit0, load0, clr0} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=10000",
        {ready0, done0, ibit0, load0, clr0});
    end
    total++;
    if ({result0, alu_a0, alu_b0} !== 24'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0",
        {result0, alu_a0, alu_b0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    rdy = 1;
    repeat (8) begin
      @(negedge clk);
      if (done0) seen = 1;
      if (!ready0) rdy = 0;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done got=%b exp=0", seen);
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", rdy);
    end
    reset_n = 1'b0;
    #2;
    start = 1'b1;
    opcode = OP_SUB;
    a_in = 6'd5;
    b_in = 6'd6;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    total++;
    if (clr0 !== 1'b1 || alu_a0 !== 6'd5) begin
      bad++;
      $display("FAIL first_start got=%b/%0d exp=1/5",
        clr0, alu_a0);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    obs_t o;
    @(negedge clk);
    total++;
    if (ready0 !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got=%b exp=1", ready0);
    end
    accept(3'b101, 6'd9, 6'd4);
    watch(12, 0, 0, 6'd9, 6'd4, o);
    total++;
    if (o.clr_at !== 0 || o.nclr !== 1) begin
      bad++;
      $display("FAIL single_clr got=%0d/%0d exp=0/1",
        o.clr_at, o.nclr);
    end
    total++;
    if (o.load_at !== 1 || o.nload !== 3) begin
      bad++;
      $display("FAIL single_load got=%0d/%0d exp=1/3",
        o.load_at, o.nload);
    end
    total++;
    if (o.bits !== 3'b101) begin
      bad++;
      $display("FAIL single_bits got=%b exp=101", o.bits);
    end
    total++;
    if (o.first !== 5 || o.ndone !== 1) begin
      bad++;
      $display("FAIL single_done got=%0d/%0d exp=5/1",
        o.first, o.ndone);
    end
    total++;
    if (o.res !== alu_f(3'b101, 6'd9, 6'd4)) begin
      bad++;
      $display("FAIL single_res got=%h exp=%h",
        o.res, alu_f(3'b101, 6'd9, 6'd4));
    end
  endtask

  task automatic test_ignored_start();
    obs_t o;
    logic [5:0] a, b;
    a = 6'($urandom);
    b = 6'($urandom);
    accept(3'b101, a, b);
    watch(12, 0, 1, a, b, o);
    total++;
    if (o.bits !== 3'b101) begin
      bad++;
      $display("FAIL ignored_bits got=%b exp=101", o.bits);
    end
    total++;
    if (o.ndone !== 1 || o.nclr !== 1) begin
      bad++;
      $display("FAIL ignored_count got=%0d/%0d exp=1/1",
        o.ndone, o.nclr);
    end
    total++;
    if (o.ab_ok !== 1'b1 || o.res !== alu_f(3'b101, a, b)) begin
      bad++;
      $display("FAIL ignored_res got=%b/%h exp=1/%h",
        o.ab_ok, o.res, alu_f(3'b101, a, b));
    end
  endtask

  task automatic test_stability();
    obs_t o;
    logic [2:0] op;
    logic [5:0] a, b;
    for (int k = 0; k < 3; k++) begin
      op = 3'($urandom);
      a = 6'($urandom);
      b = 6'($urandom);
      accept(op, a, b);
      watch(12, 1, 0, a, b, o);
      total++;
      if (o.ab_ok !== 1'b1 || o.bits !== op) begin
        bad++;
        $display("FAIL stable_%0d got=%b/%b exp=1/%b",
          k, o.ab_ok, o.bits, op);
      end
      total++;
      if (o.first !== 5 || o.res !== alu_f(op, a, b)) begin
        bad++;
        $display("FAIL stable_res_%0d got=%0d/%h exp=5/%h",
          k, o.first, o.res, alu_f(op, a, b));
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] op;
    logic [5:0] a, b;
    for (int k = 0; k < 16; k++) begin
      op = 3'($urandom);
      a = 6'($urandom);
      b = 6'($urandom);
      accept(op, a, b);
      watch(8, 0, 0, a, b, o);
      total++;
      if (o.first !== 5 || o.ndone !== 1 ||
          o.res !== alu_f(op, a, b)) begin
        bad++;
        $display("FAIL rand_%0d got=%0d/%0d/%h exp=5/1/%h",
          k, o.first, o.ndone, o.res, alu_f(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op1, op2;
    int t[2];
    logic [11:0] r[2];
    int nd;
    int n;
    op1 = 3'($urandom);
    op2 = 3'($urandom);
    nd = 0;
    t[0] = -1; t[1] = -1;
    @(negedge clk);
    opcode = op1;
    a_in = 6'd1;
    b_in = 6'd2;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i - 1;
      if (n == 0) begin
        opcode = op2;
        a_in = 6'd63;
        b_in = 6'd63;
      end
      if (nd == 1 && n == t[0] + 1) start = 1'b0;
      if (done0) begin
        if (nd < 2) begin
          t[nd] = n;
          r[nd] = result0;
        end
        nd++;
      end
    end
    start = 1'b0;
    total++;
    if (nd !== 2 || t[0] !== 5 || t[1] !== 11) begin
      bad++;
      $display("FAIL b2b_timing got=%0d/%0d/%0d exp=2/5/11",
        nd, t[0], t[1]);
    end
    total++;
    if (r[0] !== alu_f(op1, 6'd1, 6'd2)) begin
      bad++;
      $display("FAIL b2b_res1 got=%h exp=%h",
        r[0], alu_f(op1, 6'd1, 6'd2));
    end
    total++;
    if (r[1] !== alu_f(op2, 6'd63, 6'd63)) begin
      bad++;
      $display("FAIL b2b_res2 got=%h exp=%h",
        r[1], alu_f(op2, 6'd63, 6'd63));
    end
  endtask

  task automatic test_latency();
    logic [2:0] op;
    logic [5:0] a, b;
    int first, nd;
    logic [11:0] res;
    bit early;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      @(negedge clk);
      total++;
      if (ready3 !== 1'b1) begin
        bad++;
        $display("FAIL lat_ready_%0d got=%b exp=1", k, ready3);
      end
      op = 3'($urandom);
      a = 6'($urandom);
      b = 6'($urandom);
      accept(op, a, b);
      first = -1;
      nd = 0;
      res = 'x;
      early = 0;
      for (int i = 1; i <= 14; i++) begin
        @(negedge clk);
        if (done3) begin
          if (first < 0) begin
            first = i - 1;
            res = result3;
          end
          nd++;
        end
        if (first < 0 && result3 !== 12'd0) early = 1;
      end
      total++;
      if (first !== 7 || nd !== 1 || early !== 1'b0) begin
        bad++;
        $display("FAIL lat_done_%0d got=%0d/%0d/%b exp=7/1/0",
          k, first, nd, early);
      end
      total++;
      if (res !== alu_f(op, a, b)) begin
        bad++;
        $display("FAIL lat_res_%0d got=%h exp=%h",
          k, res, alu_f(op, a, b));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    opcode = 3'd0;
    a_in = 6'd0;
    b_in = 6'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_ignored_start();
    test_stability();
    test_random();
    test_back_to_back();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer that drives the serial-instruction ALU from a parallel request interface. It accepts one operation (opcode plus two operands) per handshake, clears the ALU instruction register, and shifts the opcode in bit-serially. It then waits the ALU execution latency, captures the 12-bit result and reports completion. It sits between the board-level request source (switch/button front end or a future command FSM) and the ALU instance.

## Interface
Parameters:
- DATA_W, 6, operand width (A and B)
- OP_W, 3, opcode width shifted into the ALU instruction register
- RES_W, 12, ALU result width
- EXEC_LAT, 1, cycles to wait after the last instruction bit before sampling the result (≥1)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset of all state
- start  in  1  request strobe; sampled only when ready=1
- opcode  in  OP_W  operation to load
- a_in  in  DATA_W  operand A
- b_in  in  DATA_W  operand B
- ready  out  1  high when a start will be accepted
- done  out  1  one-cycle pulse: result valid
- result  out  RES_W  captured ALU result; holds until next capture
- alu_a  out  DATA_W  operand A to ALU (registered)
- alu_b  out  DATA_W  operand B to ALU (registered)
- alu_instr_bit  out  1  serial instruction bit (ALU instruction_in)
- alu_load_en  out  1  instruction shift enable (ALU inst_load_en)
- alu_instr_clr  out  1  instruction register clear (ALU reset_instr)
- alu_result  in  RES_W  ALU result

## Operation
- States: IDLE, CLEAR, SHIFT, EXEC, DONE.
- IDLE: ready=1. start=1 → latch opcode, a_in, b_in into alu_a/alu_b and the opcode shift register; go to CLEAR.
- CLEAR: 1 cycle, alu_instr_clr=1, ready=0 → SHIFT.
- SHIFT: OP_W cycles, alu_load_en=1, alu_instr_bit = opcode MSB first; bit counter 0..OP_W-1; at count OP_W-1 → EXEC.
- EXEC: EXEC_LAT cycles, all ALU strobes 0; on the last cycle, result ← alu_result, → DONE.
- DONE: 1 cycle, done=1, ready=1. start=1 → accept new request (latch, → CLEAR), otherwise → IDLE.
- start in CLEAR/SHIFT/EXEC: ignored, no queuing; operands and opcode are unaffected.
- alu_a/alu_b are held stable from accept until the next accept.
- Input opcode/operand changes after the accept edge have no effect on the operation in flight.
- Widths are fixed; no arithmetic in this block beyond the counters. Counters are sized $clog2 of max(OP_W, EXEC_LAT)+1.

## Timing
- Reset (reset_n=0, any state, asynchronous): state=IDLE, ready=1, done=0, result=0, alu_a=0, alu_b=0, alu_instr_bit=0, alu_load_en=0, alu_instr_clr=0, counters=0.
- Reset mid-operation aborts the operation: no done, result=0.
- First start is honoured on the first rising edge after reset_n deasserts.
- Accept at edge t0 → CLEAR during [t0, t0+1) → SHIFT during [t0+1, t0+1+OP_W) → EXEC for EXEC_LAT cycles → done high during cycle t0+1+OP_W+EXEC_LAT. Defaults: done 5 cycles after accept.
- Back-to-back: start held high yields one operation per 2+OP_W+EXEC_LAT cycles (6 at defaults).
- result changes only on the edge entering DONE.
- All outputs are registered; no combinational input→output path except ready, which is a state decode.

## Structure
- Shared package alu_pkg: state enum, OP_W/DATA_W/RES_W defaults, opcode constants (e.g. OP_ADD, OP_SUB, OP_MUL) used by the ALU, this block and benches.
- One sub-module: alu_op_shifter (parallel-load, MSB-first shift register with bit counter and last flag), instantiated for the SHIFT phase.
- The FSM and result capture stay in alu_seq_ctrl.

## Test plan
- Reset: drive reset_n=0 mid-SHIFT → all outputs at reset values immediately; after release, ready=1 and no done.
- Single op: opcode=3'b101, a=6'd9, b=6'd4, pulse start → alu_instr_clr for 1 cycle, then alu_load_en for 3 cycles with bits 1,0,1; done 5 cycles after accept; result = the model ALU value.
- Ignored start: pulse start again during SHIFT with opcode=3'b010 → shifted bits remain 1,0,1; exactly one done.
- Back-to-back: start held high for two ops (a=1,b=2 then a=63,b=63) → done pulses 6 cycles apart; results match the model.
- Input stability: change a_in/b_in/opcode each cycle after accept → alu_a/alu_b and the shifted bits are unchanged until the next accept.
- Latency parameter: EXEC_LAT=3 → done 7 cycles after accept; result sampled only in the last EXEC cycle (the model ALU updates late and the captured value must be the final one).
